// File: rtl/iencoder.sv
// Field-level RV32I instruction encoder feeding a program-memory write port.
// Packs decoded fields into instruction words and writes them at auto-incrementing addresses.
`ifndef INST_TYPE_WIDTH
`define INST_TYPE_WIDTH 3
`define INST_TYPE_IMM 3'd0
`define INST_TYPE_INT_IMM 3'd1
`define INST_TYPE_INT_REG 3'd2
`define INST_TYPE_BRANCH 3'd3
`endif
`ifndef FUNCT_WIDTH
`define FUNCT_WIDTH 4
`define FUNCT_ADD 4'd0
`define FUNCT_SUB 4'd1
`define FUNCT_EQ 4'd2
`endif
`ifndef REG_WIDTH
`define REG_WIDTH 5
`endif
`ifndef IMM_WIDTH
`define IMM_WIDTH 32
`endif
`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif

module iencoder #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
    parameter int unsigned ERR_CNT_WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        in_last,
    input  logic [`INST_TYPE_WIDTH-1:0] inst_type,
    input  logic [`FUNCT_WIDTH-1:0]     funct,
    input  logic [`REG_WIDTH-1:0]       rd,
    input  logic [`REG_WIDTH-1:0]       rs1,
    input  logic [`REG_WIDTH-1:0]       rs2,
    input  logic [`IMM_WIDTH-1:0]       imm,
    output logic                        mem_valid,
    input  logic                        mem_ready,
    output logic [ADDR_WIDTH-1:0]       mem_addr,
    output logic [`INST_WIDTH-1:0]      mem_data,
    output logic                        err,
    output logic [ERR_CNT_WIDTH-1:0]    err_count,
    output logic                        done
);

    localparam logic signed [`IMM_WIDTH-1:0] AddiMin   = -2048;
    localparam logic signed [`IMM_WIDTH-1:0] AddiMax   = 2047;
    localparam logic signed [`IMM_WIDTH-1:0] BranchMin = -4096;
    localparam logic signed [`IMM_WIDTH-1:0] BranchMax = 4094;

    logic                     mem_valid_q, mem_valid_d;
    logic [ADDR_WIDTH-1:0]    mem_addr_q, mem_addr_d;
    logic [`INST_WIDTH-1:0]   mem_data_q, mem_data_d;
    logic                     last_q, last_d;
    logic [ADDR_WIDTH-1:0]    next_addr_q, next_addr_d;
    logic                     err_q, err_d;
    logic [ERR_CNT_WIDTH-1:0] err_count_q, err_count_d;
    logic                     done_q, done_d;

    logic                     start_eff, mem_done, accept, enc_ok;
    logic [`INST_WIDTH-1:0]   enc_word;
    logic signed [`IMM_WIDTH-1:0] imm_s;

    assign imm_s = imm;

    always_comb begin
        enc_word = '0;
        enc_ok   = 1'b0;
        case (inst_type)
            `INST_TYPE_IMM: begin
                enc_word = {imm[31:12], rd, 7'b0110111};
                enc_ok   = (imm[11:0] == 12'd0);
            end
            `INST_TYPE_INT_IMM: begin
                if (funct == `FUNCT_ADD) begin
                    enc_word = {imm[11:0], rs1, 3'b000, rd, 7'b0010011};
                    enc_ok   = (imm_s >= AddiMin) && (imm_s <= AddiMax);
                end
            end
            `INST_TYPE_INT_REG: begin
                if (funct == `FUNCT_ADD || funct == `FUNCT_SUB) begin
                    enc_word = {(funct == `FUNCT_SUB) ? 7'd32 : 7'd0, rs2, rs1, 3'b000, rd,
                                7'b0110011};
                    enc_ok   = 1'b1;
                end
            end
            `INST_TYPE_BRANCH: begin
                if (funct == `FUNCT_EQ) begin
                    enc_word = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11],
                                7'b1100011};
                    enc_ok   = !imm[0] && (imm_s >= BranchMin) && (imm_s <= BranchMax);
                end
            end
            default: ;
        endcase
    end

    // Start only lands between writes; a pending last write also closes the input side.
    assign start_eff = start && !mem_valid_q;
    assign mem_done  = mem_valid_q && mem_ready;
    assign in_ready  = (!mem_valid_q || mem_ready) && !done_q && !(mem_valid_q && last_q)
                       && !start_eff;
    assign accept    = in_valid && in_ready;

    always_comb begin
        mem_valid_d = mem_valid_q;
        mem_addr_d  = mem_addr_q;
        mem_data_d  = mem_data_q;
        last_d      = last_q;
        next_addr_d = next_addr_q;
        err_d       = 1'b0;
        err_count_d = err_count_q;
        done_d      = done_q;
        if (mem_done) begin
            mem_valid_d = 1'b0;
            if (last_q) done_d = 1'b1;
        end
        if (start_eff) begin
            next_addr_d = BASE_ADDR;
            mem_addr_d  = BASE_ADDR;
            done_d      = 1'b0;
            err_count_d = '0;
        end else if (accept) begin
            if (enc_ok) begin
                mem_valid_d = 1'b1;
                mem_addr_d  = next_addr_q;
                mem_data_d  = enc_word;
                last_d      = in_last;
                next_addr_d = next_addr_q + ADDR_WIDTH'(4);
            end else begin
                err_d       = 1'b1;
                err_count_d = (&err_count_q) ? err_count_q : err_count_q + 1'b1;
                if (in_last) done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_valid_q <= 1'b0;
            mem_addr_q  <= BASE_ADDR;
            mem_data_q  <= '0;
            last_q      <= 1'b0;
            next_addr_q <= BASE_ADDR;
            err_q       <= 1'b0;
            err_count_q <= '0;
            done_q      <= 1'b0;
        end else begin
            mem_valid_q <= mem_valid_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
            last_q      <= last_d;
            next_addr_q <= next_addr_d;
            err_q       <= err_d;
            err_count_q <= err_count_d;
            done_q      <= done_d;
        end
    end

    assign mem_valid = mem_valid_q;
    assign mem_addr  = mem_addr_q;
    assign mem_data  = mem_data_q;
    assign err       = err_q;
    assign err_count = err_count_q;
    assign done      = done_q;

endmodule

// File: tb/tb_iencoder.sv
// Directed bench for iencoder: hand-encoded RV32I words, stalls, rejections, start and reset.
`timescale 1ns/1ps
module tb_iencoder;

    localparam logic [2:0] TImm    = 3'd0;
    localparam logic [2:0] TIntImm = 3'd1;
    localparam logic [2:0] TIntReg = 3'd2;
    localparam logic [2:0] TBranch = 3'd3;
    localparam logic [3:0] FAdd    = 4'd0;
    localparam logic [3:0] FSub    = 4'd1;
    localparam logic [3:0] FEq     = 4'd2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_last = 1'b0;
    logic [2:0]  inst_type = '0;
    logic [3:0]  funct = '0;
    logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
    logic [31:0] imm = '0;
    logic        mem_valid;
    logic        mem_ready = 1'b1;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        err;
    logic [7:0]  err_count;
    logic        done;

    int n_checks = 0;
    int n_errors = 0;
    int exp_errs = 0;

    iencoder dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .inst_type (inst_type),
        .funct     (funct),
        .rd        (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .imm       (imm),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .err       (err),
        .err_count (err_count),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fields(input logic [2:0] t, input logic [3:0] f, input logic [4:0] d,
                              input logic [4:0] s1, input logic [4:0] s2, input logic [31:0] i,
                              input logic last);
        inst_type = t; funct = f; rd = d; rs1 = s1; rs2 = s2; imm = i; in_last = last;
        in_valid = 1'b1;
    endtask

    task automatic send_ok(input string tag, input logic [2:0] t, input logic [3:0] f,
                           input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                           input logic [31:0] i, input logic last, input logic [31:0] exp_addr,
                           input logic [31:0] exp_data);
        set_fields(t, f, d, s1, s2, i, last);
        #1;
        check_eq({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
        check_eq({tag, ".mem_valid"}, 32'(mem_valid), 32'd1);
        check_eq({tag, ".mem_addr"}, mem_addr, exp_addr);
        check_eq({tag, ".mem_data"}, mem_data, exp_data);
        check_eq({tag, ".err"}, 32'(err), 32'd0);
    endtask

    task automatic send_reject(input string tag, input logic [2:0] t, input logic [3:0] f,
                               input logic [31:0] i);
        set_fields(t, f, 5'd1, 5'd1, 5'd2, i, 1'b0);
        step();
        in_valid = 1'b0;
        exp_errs++;
        check_eq({tag, ".err"}, 32'(err), 32'd1);
        check_eq({tag, ".mem_valid"}, 32'(mem_valid), 32'd0);
        check_eq({tag, ".err_count"}, 32'(err_count), 32'(exp_errs));
    endtask

    initial begin
        // Reset state
        step(); step();
        check_eq("rst.mem_valid", 32'(mem_valid), 32'd0);
        check_eq("rst.mem_addr", mem_addr, 32'h0);
        check_eq("rst.mem_data", mem_data, 32'h0);
        check_eq("rst.err", 32'(err), 32'd0);
        check_eq("rst.err_count", 32'(err_count), 32'd0);
        check_eq("rst.done", 32'(done), 32'd0);
        rst = 1'b1;
        step();

        // Single ADDI
        send_ok("addi", TIntImm, FAdd, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 32'h0, 32'h00500093);
        step();
        check_eq("addi.drain", 32'(mem_valid), 32'd0);
        start = 1'b1;
        step();
        start = 1'b0;

        // Back-to-back stream
        send_ok("lui", TImm, FAdd, 5'd2, 5'd0, 5'd0, 32'h12345000, 1'b0, 32'h0, 32'h12345137);
        send_ok("add", TIntReg, FAdd, 5'd3, 5'd1, 5'd2, 32'h0, 1'b0, 32'h4, 32'h002081B3);
        send_ok("sub", TIntReg, FSub, 5'd3, 5'd1, 5'd2, 32'h0, 1'b0, 32'h8, 32'h402081B3);

        // Branches, last instruction
        send_ok("beq8", TBranch, FEq, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0, 32'hC, 32'h00208463);
        send_ok("beqm4", TBranch, FEq, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 1'b1, 32'h10,
                32'hFE208EE3);
        check_eq("last.done_early", 32'(done), 32'd0);
        check_eq("last.in_ready_pend", 32'(in_ready), 32'd0);
        step();
        check_eq("last.done", 32'(done), 32'd1);
        check_eq("last.in_ready", 32'(in_ready), 32'd0);
        check_eq("last.mem_valid", 32'(mem_valid), 32'd0);

        // Start and in_valid together: start wins
        set_fields(TIntImm, FAdd, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0);
        start = 1'b1;
        #1;
        check_eq("start.in_ready", 32'(in_ready), 32'd0);
        step();
        start = 1'b0;
        in_valid = 1'b0;
        check_eq("start.mem_valid", 32'(mem_valid), 32'd0);
        check_eq("start.done", 32'(done), 32'd0);

        // Backpressure
        mem_ready = 1'b0;
        send_ok("stall0", TIntImm, FAdd, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 32'h0, 32'h00500093);
        set_fields(TIntImm, FAdd, 5'd2, 5'd0, 5'd0, 32'd7, 1'b0);
        for (int k = 0; k < 5; k++) begin
            check_eq("stall.in_ready", 32'(in_ready), 32'd0);
            check_eq("stall.mem_addr", mem_addr, 32'h0);
            check_eq("stall.mem_data", mem_data, 32'h00500093);
            step();
        end
        mem_ready = 1'b1;
        #1;
        check_eq("stall.release_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        check_eq("stall1.mem_valid", 32'(mem_valid), 32'd1);
        check_eq("stall1.mem_addr", mem_addr, 32'h4);
        check_eq("stall1.mem_data", mem_data, 32'h00700113);
        step();

        // Rejections and boundaries
        send_reject("rej_addi2048", TIntImm, FAdd, 32'd2048);
        send_reject("rej_beq3", TBranch, FEq, 32'd3);
        send_reject("rej_pair", TIntReg, FEq, 32'd0);
        send_reject("rej_lui_low", TImm, FAdd, 32'h12345001);
        send_reject("rej_beq4096", TBranch, FEq, 32'd4096);
        send_reject("rej_addim2049", TIntImm, FAdd, 32'hFFFF_F7FF);
        send_ok("addim2048", TIntImm, FAdd, 5'd1, 5'd0, 5'd0, 32'hFFFF_F800, 1'b0, 32'h8,
                32'h80000093);
        send_ok("beqm4096", TBranch, FEq, 5'd0, 5'd1, 5'd2, 32'hFFFF_F000, 1'b0, 32'hC,
                32'h80208063);
        step();

        // Reset in the middle of a stalled write
        mem_ready = 1'b0;
        send_ok("pre_rst", TIntImm, FAdd, 5'd5, 5'd0, 5'd0, 32'd1, 1'b0, 32'h10, 32'h00100293);
        step();
        rst = 1'b0;
        #1;
        check_eq("mrst.mem_valid", 32'(mem_valid), 32'd0);
        check_eq("mrst.err_count", 32'(err_count), 32'd0);
        check_eq("mrst.done", 32'(done), 32'd0);
        check_eq("mrst.mem_addr", mem_addr, 32'h0);
        step();
        rst = 1'b1;
        mem_ready = 1'b1;
        exp_errs = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        send_ok("post_rst", TIntImm, FAdd, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 32'h0, 32'h00500093);
        step();

        // Rejected last field set still finishes the program
        set_fields(TIntImm, FAdd, 5'd1, 5'd0, 5'd0, 32'd4096, 1'b1);
        step();
        in_valid = 1'b0;
        check_eq("rejlast.err", 32'(err), 32'd1);
        check_eq("rejlast.done", 32'(done), 32'd1);
        check_eq("rejlast.in_ready", 32'(in_ready), 32'd0);
        check_eq("rejlast.mem_valid", 32'(mem_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/iencoder.md
Name: iencoder

Overview:
- Field-level instruction encoder and program-memory writer for the copperv core; inverse of the core's instruction decoder.
- Accepts decoded fields (inst_type, funct, rd, rs1, rs2, imm) over a valid/ready handshake and packs them into 32-bit RV32I words.
- Writes each word to instruction memory at an auto-incrementing address.
- Used by the boot/program loader and by self-checking benches to generate programs the decoder must round-trip.

Parameters:
- BASE_ADDR, 32'h0000_0000, address of the first word written after reset or start.
- ADDR_WIDTH, 32, width of mem_addr.
- ERR_CNT_WIDTH, 8, width of the saturating error counter.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle pulse; reloads address to BASE_ADDR and clears done and err_count.
- in_valid  input  1  field set valid.
- in_ready  output  1  encoder can accept a field set.
- in_last  input  1  current field set is the final instruction of the program.
- inst_type  input  `INST_TYPE_WIDTH  `INST_TYPE_IMM / `INST_TYPE_INT_IMM / `INST_TYPE_INT_REG / `INST_TYPE_BRANCH.
- funct  input  `FUNCT_WIDTH  `FUNCT_ADD / `FUNCT_SUB / `FUNCT_EQ.
- rd, rs1, rs2  input  `REG_WIDTH each  register indices.
- imm  input  `IMM_WIDTH  full sign-extended immediate value, not pre-shifted.
- mem_valid  output  1  write request valid.
- mem_ready  input  1  memory accepts write.
- mem_addr  output  ADDR_WIDTH  byte address, word aligned.
- mem_data  output  `INST_WIDTH  encoded instruction.
- err  output  1  one-cycle pulse on a rejected field set.
- err_count  output  ERR_CNT_WIDTH  saturating count of rejections.
- done  output  1  last instruction written; sticky until start or reset.

Behaviour:
- Reset values (rst low, asynchronous): mem_valid=0, mem_addr=BASE_ADDR, mem_data=0, err=0, err_count=0, done=0, internal next-address=BASE_ADDR.
- Handshakes:
  - in_ready = !mem_valid || mem_ready (one-deep output register, no bubble).
  - A field set is accepted on in_valid && in_ready.
  - A memory write completes on mem_valid && mem_ready.
  - mem_addr and mem_data are held stable while mem_valid && !mem_ready.
- Latency: field set accepted at edge N -> mem_valid=1 with encoded word from edge N (visible in cycle N+1).
- Encoding, unused fields ignored:
  - IMM (LUI): {imm[31:12], rd, 7'b0110111}.
  - INT_IMM + ADD (ADDI): {imm[11:0], rs1, 3'b000, rd, 7'b0010011}.
  - INT_REG + ADD/SUB: {7'd0 or 7'd32, rs2, rs1, 3'b000, rd, 7'b0110011}.
  - BRANCH + EQ: {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011}.
- Rejection conditions; on any of these the word is not written, the address does not advance, err pulses in cycle N+1, err_count increments (saturates at all-ones):
  - unsupported inst_type/funct pair;
  - LUI with imm[11:0]!=0;
  - ADDI with imm outside -2048..2047;
  - BRANCH with imm[0]!=0 or imm outside -4096..4094.
- Address: the next-address register increments by 4 at each acceptance of a valid field set; it wraps modulo 2^ADDR_WIDTH with no flag.
- Done: set when the write tagged in_last completes.
  - A rejected in_last field set also sets done, in the cycle after acceptance.
  - While done=1, in_ready=0.
- Start:
  - Ignored (no effect) while mem_valid=1.
  - Otherwise it takes effect at the next edge.
  - If start and in_valid coincide, start wins and the field set is not accepted that cycle.
- Reset asserted mid-write drops the pending write; no partial state survives.

Test Plan:
- ADDI x1,x0,5 with mem_ready=1 -> one cycle later mem_valid=1, mem_addr=0x0, mem_data=0x00500093.
- Stream LUI x2,0x12345000; ADD x3,x1,x2; SUB x3,x1,x2 -> data 0x12345137, 0x002081B3, 0x402081B3 at addr 0x0, 0x4, 0x8, back-to-back with no bubbles.
- BEQ x1,x2,+8 then BEQ x1,x2,-4 (in_last=1) -> 0x00208463, 0xFE208EE3; done=1 after second write completes; in_ready=0 afterwards.
- Hold mem_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, mem_addr/mem_data stable; release mem_ready -> write completes, next word follows in the next cycle.
- ADDI imm=2048, then BRANCH imm=3 -> two err pulses, err_count=2, no mem_valid, next valid write lands at the unchanged address.
- Assert rst mid-stall, then pulse start -> mem_valid=0, err_count=0, done=0, next write at BASE_ADDR.
